// File: rtl/fht_pkg.sv
// Shared constants, state encoding and bit-reversal helper for the FHT datapath.
package fht_pkg;

  localparam int FHT_N_BIT = 10;
  localparam int FHT_A_BIT = 8;
  localparam int FHT_D_BIT = 16;
  localparam int FHT_BANKS = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_START = 3'd3,
    ST_ACK   = 3'd4,
    ST_BUSY  = 3'd5
  } fht_state_e;

  function automatic logic [FHT_N_BIT-1:0] bitrev(input logic [FHT_N_BIT-1:0] v);
    logic [FHT_N_BIT-1:0] r;
    for (int i = 0; i < FHT_N_BIT; i++) begin
      r[i] = v[FHT_N_BIT-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fht_bitrev.sv
// Combinational N_BIT bit reversal; shared by the loader and the output unloader.
module fht_bitrev
  import fht_pkg::*;
#(
  parameter int N_BIT = FHT_N_BIT
) (
  input  logic [N_BIT-1:0] idx,
  output logic [N_BIT-1:0] rev
);

  always_comb begin
    rev = '0;
    for (int i = 0; i < N_BIT; i++) begin
      rev[i] = idx[N_BIT-1-i];
    end
  end

endmodule

// File: rtl/fht_loader.sv
// Frame loader: writes a 1024-sample stream into four banks in bit-reversed order
// and hands the frame to the FHT controller with a one-cycle start pulse.
module fht_loader
  import fht_pkg::*;
#(
  parameter int N_BIT = FHT_N_BIT,
  parameter int A_BIT = FHT_A_BIT,
  parameter int D_BIT = FHT_D_BIT
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iCLR,
  input  logic [D_BIT-1:0] iDATA,
  input  logic             iVALID,
  output logic             oREADY,
  input  logic             iFHT_RDY,
  output logic             oLOAD_ACT,
  output logic [A_BIT-1:0] oADDR_WR,
  output logic [D_BIT-1:0] oDATA,
  output logic             oWE_0,
  output logic             oWE_1,
  output logic             oWE_2,
  output logic             oWE_3,
  output logic             oSTART,
  output logic [N_BIT-1:0] oCNT,
  output logic [2:0]       oSTATE
);

  // Handshake: a sample is taken on a rising edge where iVALID and oREADY are
  // both high; oREADY comes from a register only, so it never depends on iVALID.

  fht_state_e       state;
  logic [N_BIT-1:0] rev;
  logic [3:0]       we;
  logic             accept;
  logic             last;

  fht_bitrev #(.N_BIT(N_BIT)) u_bitrev (
    .idx (oCNT),
    .rev (rev)
  );

  // iCLR has priority over an accept in the same cycle
  assign accept = (state == ST_LOAD) && iVALID && !iCLR;
  assign last   = (oCNT == {N_BIT{1'b1}});

  assign oWE_0  = we[0];
  assign oWE_1  = we[1];
  assign oWE_2  = we[2];
  assign oWE_3  = we[3];
  assign oSTATE = state;

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state     <= ST_IDLE;
      oREADY    <= 1'b0;
      oLOAD_ACT <= 1'b0;
      oSTART    <= 1'b0;
      oADDR_WR  <= '0;
      oDATA     <= '0;
      oCNT      <= '0;
      we        <= '0;
    end else begin
      we <= '0;
      if (iCLR) begin
        state     <= ST_IDLE;
        oCNT      <= '0;
        oREADY    <= 1'b0;
        oLOAD_ACT <= 1'b0;
        oSTART    <= 1'b0;
      end else begin
        if (accept) begin
          oDATA    <= iDATA;
          oADDR_WR <= rev[N_BIT-1:2];
          we       <= 4'b0001 << rev[1:0];
          oCNT     <= oCNT + 1'b1;
        end
        case (state)
          ST_IDLE: begin
            if (iFHT_RDY) begin
              state     <= ST_LOAD;
              oREADY    <= 1'b1;
              oLOAD_ACT <= 1'b1;
            end
          end
          ST_LOAD: begin
            if (accept && last) begin
              state  <= ST_FLUSH;
              oREADY <= 1'b0;
            end
          end
          ST_FLUSH: begin
            state     <= ST_START;
            oLOAD_ACT <= 1'b0;
            oSTART    <= 1'b1;
          end
          ST_START: begin
            state  <= ST_ACK;
            oSTART <= 1'b0;
          end
          ST_ACK: begin
            if (!iFHT_RDY) state <= ST_BUSY;
          end
          ST_BUSY: begin
            if (iFHT_RDY) begin
              state     <= ST_LOAD;
              oREADY    <= 1'b1;
              oLOAD_ACT <= 1'b1;
            end
          end
          default: begin
            state     <= ST_IDLE;
            oREADY    <= 1'b0;
            oLOAD_ACT <= 1'b0;
            oSTART    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
